// File: rtl/entrada_decimal.sv
// Decimal keypad entry: decodes active-low 7-segment digits into a binary
// accumulator, presents the committed value with a valid/ready handshake.
module entrada_decimal #(
  parameter int MAX_DIGITS = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [6:0]  seg_in,
  input  logic        seg_valid,
  output logic        seg_ready,
  input  logic        commit,
  input  logic        clear,
  output logic [31:0] valor,
  output logic        valor_valid,
  input  logic        valor_ready,
  output logic [3:0]  digit_count,
  output logic        erro
);

  typedef enum logic [1:0] {IDLE, ENTRY, HOLD, ERROR} state_t;

  localparam logic [3:0] MAXD = 4'(MAX_DIGITS);

  state_t      state;
  logic [31:0] acc;

  logic        dig_ok;
  logic [3:0]  dig;
  logic        accept;
  logic [31:0] acc_nxt;
  logic [3:0]  cnt_nxt;

  // Pattern bit order is {g,f,e,d,c,b,a}; "1" has two legal encodings.
  always_comb begin
    dig_ok = 1'b1;
    dig    = 4'd0;
    case (seg_in)
      7'b1000000: dig = 4'd0;
      7'b1111001,
      7'b1001111: dig = 4'd1;
      7'b0100100: dig = 4'd2;
      7'b0110000: dig = 4'd3;
      7'b0011001: dig = 4'd4;
      7'b0010010: dig = 4'd5;
      7'b0000010: dig = 4'd6;
      7'b1111000: dig = 4'd7;
      7'b0000000: dig = 4'd8;
      7'b0010000: dig = 4'd9;
      default:    dig_ok = 1'b0;
    endcase
  end

  assign seg_ready = ((state == IDLE) || (state == ENTRY)) && (digit_count < MAXD);
  assign accept    = seg_valid && seg_ready;

  always_comb begin
    acc_nxt = acc;
    cnt_nxt = digit_count;
    if (accept && dig_ok) begin
      acc_nxt = (acc << 3) + (acc << 1) + {28'd0, dig};
      cnt_nxt = digit_count + 4'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      acc         <= '0;
      valor       <= '0;
      valor_valid <= 1'b0;
      digit_count <= '0;
      erro        <= 1'b0;
    end else if (clear) begin
      state       <= IDLE;
      acc         <= '0;
      valor_valid <= 1'b0;
      digit_count <= '0;
      erro        <= 1'b0;
    end else begin
      case (state)
        IDLE, ENTRY: begin
          if (accept && !dig_ok) begin
            // a bad digit wins over a same-cycle commit
            erro  <= 1'b1;
            state <= ERROR;
          end else begin
            acc         <= acc_nxt;
            digit_count <= cnt_nxt;
            if (commit) begin
              valor       <= acc_nxt;
              valor_valid <= 1'b1;
              state       <= HOLD;
            end else if (accept) begin
              state <= ENTRY;
            end
          end
        end
        HOLD: begin
          if (valor_ready) begin
            valor_valid <= 1'b0;
            acc         <= '0;
            digit_count <= '0;
            state       <= IDLE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/entrada_decimal.md
ENTRADA_DECIMAL -- requirements
Module: entrada_decimal

Interface
REQ-001 SHALL have parameter MAX_DIGITS, default 8, maximum decimal digits accepted per entry; legal range 1..9.
REQ-002 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port seg_in  input  7  active-low 7-segment digit pattern {g,f,e,d,c,b,a}.
REQ-005 SHALL have port seg_valid  input  1  seg_in carries a digit this cycle.
REQ-006 SHALL have port seg_ready  output  1  block can accept a digit this cycle.
REQ-007 SHALL have port commit  input  1  request to finalize the accumulated value.
REQ-008 SHALL have port clear  input  1  synchronous abort of the current entry.
REQ-009 SHALL have port valor  output  32  committed unsigned binary value.
REQ-010 SHALL have port valor_valid  output  1  valor holds a committed result awaiting consumption.
REQ-011 SHALL have port valor_ready  input  1  consumer accepts valor.
REQ-012 SHALL have port digit_count  output  4  number of digits accepted in the current entry.
REQ-013 SHALL have port erro  output  1  sticky invalid-pattern flag.

Function
REQ-014 SHALL decode patterns: 0=1000000, 1=1111001 or 1001111, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; every other pattern, including 1111111, is invalid.
REQ-015 SHALL implement states IDLE (digit_count=0), ENTRY (1..MAX_DIGITS digits), HOLD (result presented), ERROR.
REQ-016 SHALL drive seg_ready=1 only in IDLE or ENTRY with digit_count<MAX_DIGITS; seg_ready=0 in HOLD, in ERROR, and when digit_count=MAX_DIGITS.
REQ-017 On accept (seg_valid&&seg_ready) of a valid pattern d: acc <= acc*10+d, computed as (acc<<3)+(acc<<1)+d in 32 bits; digit_count increments; state becomes ENTRY; both take effect next cycle.
REQ-018 seg_valid while seg_ready=0 SHALL be ignored, with no state change and no erro.
REQ-019 On accept of an invalid pattern: acc and digit_count unchanged; erro <= 1; state <= ERROR.
REQ-020 commit in IDLE or ENTRY SHALL load valor <= acc and set valor_valid=1 next cycle; state <= HOLD; commit in IDLE yields valor=0.
REQ-021 Same-cycle valid digit accept and commit SHALL include the digit: valor <= acc*10+d.
REQ-022 Same-cycle invalid digit accept and commit SHALL take the ERROR path; no commit occurs.
REQ-023 In HOLD: valor and valor_valid SHALL hold until valor_ready=1; on that cycle's edge, valor_valid <= 0, acc <= 0, digit_count <= 0, state <= IDLE; valor retains its last value.
REQ-024 In HOLD and ERROR, commit SHALL be ignored; ERROR is left only via clear or reset.
REQ-025 clear SHALL have top priority over all inputs: next cycle acc=0, digit_count=0, erro=0, valor_valid=0, state=IDLE; valor retains its value; a pending HOLD result is discarded.
REQ-026 No overflow SHALL be possible: at most 999,999,999 for MAX_DIGITS=9, which is < 2^32.

Reset
REQ-027 reset low SHALL immediately force state=IDLE, acc=0, valor=0, valor_valid=0, digit_count=0, erro=0, seg_ready=1, regardless of clock, including mid-HOLD or mid-ENTRY.
REQ-028 After reset deasserts, the first accept SHALL occur no earlier than the first rising clock edge.

Verification
REQ-029 Stimulus: reset, then digits 1111001, 0100100, 0110000, then commit -> digit_count=3, valor=123, valor_valid=1; valor_ready pulse -> valor_valid=0, digit_count=0, valor still 123.
REQ-030 Stimulus: eight 0010000 digits -> seg_ready=0 after the 8th; a 9th seg_valid is ignored; commit -> valor=99999999.
REQ-031 Stimulus: digit 0010010 (5), then 1111111 -> erro=1, seg_ready=0, commit ignored (valor_valid=0); clear -> erro=0, seg_ready=1, digit_count=0.
REQ-032 Stimulus: digit 0011001 (4), then 1111000 (7) with commit in the same cycle -> valor=47; separately, commit with no digits -> valor=0, valor_valid=1.
REQ-033 Stimulus: digits 1001111, 1000000 (legacy-encoding 1, then 0), commit -> valor=10.
REQ-034 Stimulus: reset asserted mid-HOLD with valor=123 -> valor=0 and valor_valid=0 with no clock edge; clear asserted in HOLD -> valor_valid=0 next cycle.
